mux_4to1: RTL and testbench

MUX_4TO1 -- requirements
Module: mux_4to1

---
 rtl/mux_pkg.sv | 16 +
 rtl/mux_4to1_comb.sv | 35 +++
 rtl/mux_4to1.sv | 96 +++++++++
 tb/tb_mux_4to1.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Types and constants shared by the 4-to-1 multiplexer files.
//   sel_t        : 2-bit select code
//   SEL_IN0..3   : select codes that pick in0..in3
// -----------------------------------------------------------------------------
package mux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_IN0 = 2'b00;
    localparam sel_t SEL_IN1 = 2'b01;
    localparam sel_t SEL_IN2 = 2'b10;
    localparam sel_t SEL_IN3 = 2'b11;

endpackage : mux_pkg

// File: rtl/mux_4to1_comb.sv
// -----------------------------------------------------------------------------
// mux_4to1_comb
//   Purely combinational 4-to-1 select. There is no clock and no enable, so
//   the output follows sel and the data inputs with zero latency.
//   Parameters : N   - data width (>= 1)
//   Inputs     : in0..in3 [N-1:0] data, sel [1:0] select code
//   Output     : out [N-1:0] the selected input
// -----------------------------------------------------------------------------
module mux_4to1_comb
    import mux_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    input  logic [1:0]   sel,
    output logic [N-1:0] out
);

    always_comb begin
        // NOTE: assign a default before the case so that no path through this
        // block leaves out unassigned; an unassigned path would infer a latch.
        out = in0;
        case (sel_t'(sel))
            SEL_IN0: out = in0;
            SEL_IN1: out = in1;
            SEL_IN2: out = in2;
            SEL_IN3: out = in3;
            default: out = in0;
        endcase
    end

endmodule : mux_4to1_comb

// File: rtl/mux_4to1.sv
// -----------------------------------------------------------------------------
// mux_4to1
//   4-to-1 multiplexer with a combinational output and a registered copy.
//   The registered copy loads on every enabled edge; a one-cycle pulse flags
//   an enabled capture whose select code differs from the previous capture.
//
//   Parameters : N          - data width (>= 1)
//   Inputs     : clk        - clock, rising edge
//                rst_n      - synchronous active-low reset
//                in0..in3   - data inputs [N-1:0]
//                sel        - select code [1:0]
//                en         - capture enable for the registered path
//   Outputs    : out        - combinational selected data [N-1:0]
//                out_q      - registered selected data [N-1:0]
//                out_valid  - out_q was captured on the last edge under en
//                sel_chg    - captured sel differs from the previous capture
//                out_par    - even parity of out_q (only with
//                             MUX_4TO1_PARITY_EN defined)
//
//   Build option: define MUX_4TO1_PARITY_EN to add the out_par port.
// -----------------------------------------------------------------------------
module mux_4to1
    import mux_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    input  logic [1:0]   sel,
    input  logic         en,
    output logic [N-1:0] out,
    output logic [N-1:0] out_q,
    output logic         out_valid,
    output logic         sel_chg
`ifdef MUX_4TO1_PARITY_EN
    ,
    output logic         out_par
`endif
);

    sel_t sel_last;
    // Set by the first enabled capture after reset. Without it, a first
    // capture with sel != 00 would compare against the reset value of
    // sel_last and raise a false change pulse.
    logic have_prev;

    mux_4to1_comb #(
        .N (N)
    ) u_comb (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .sel (sel),
        .out (out)
    );

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
            sel_chg   <= 1'b0;
            sel_last  <= SEL_IN0;
            have_prev <= 1'b0;
        end else if (en) begin
            out_q     <= out;
            out_valid <= 1'b1;
            sel_chg   <= have_prev && (sel_t'(sel) != sel_last);
            sel_last  <= sel_t'(sel);
            have_prev <= 1'b1;
        end else begin
            // out_q and the change history hold; the status flags drop.
            out_valid <= 1'b0;
            sel_chg   <= 1'b0;
        end
    end

`ifdef MUX_4TO1_PARITY_EN
    // Registered from the same source and on the same edges as out_q, so it
    // always equals the XOR reduction of out_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_par <= 1'b0;
        end else if (en) begin
            out_par <= ^out;
        end
    end
`endif

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// -----------------------------------------------------------------------------
// tb_mux_4to1
//   Self-checking bench for mux_4to1 (N = 8): a directed vector table followed
//   by randomized cycles compared against a behavioural model.
//   Define MUX_4TO1_PARITY_EN to also exercise out_par.
// -----------------------------------------------------------------------------
module tb_mux_4to1;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] in0, in1, in2, in3;
    logic [1:0]   sel;
    logic         en;
    logic [N-1:0] out;
    logic [N-1:0] out_q;
    logic         out_valid;
    logic         sel_chg;
`ifdef MUX_4TO1_PARITY_EN
    logic         out_par;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_4to1 #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .sel       (sel),
        .en        (en),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid),
        .sel_chg   (sel_chg)
`ifdef MUX_4TO1_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive, check the combinational output, take the edge,
    // then check the registered outputs on the falling edge.
    task automatic apply(input string tag, input logic r, input logic e,
                         input logic [1:0] s, input logic [3:0][N-1:0] din,
                         input logic [N-1:0] exp_out, input logic [N-1:0] exp_q,
                         input logic exp_v, input logic exp_c);
        rst_n = r;
        en    = e;
        sel   = s;
        in0   = din[0];
        in1   = din[1];
        in2   = din[2];
        in3   = din[3];
        #1;
        check({tag, ".out"}, 32'(out), 32'(exp_out));
        @(posedge clk);
        @(negedge clk);
        check({tag, ".out_q"},     32'(out_q),     32'(exp_q));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_v));
        check({tag, ".sel_chg"},   32'(sel_chg),   32'(exp_c));
`ifdef MUX_4TO1_PARITY_EN
        check({tag, ".out_par"},   32'(out_par),   32'(^exp_q));
`endif
    endtask

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [1:0] sel;
        logic [7:0] exp_out;
        logic [7:0] exp_q;
        logic       exp_valid;
        logic       exp_chg;
    } vec_t;

    // Behavioural model state: last captured select, -1 when nothing has been
    // captured since reset.
    int           m_last;
    logic [N-1:0] m_q;

    initial begin
        logic [3:0][N-1:0] pat;
        vec_t              tbl[15];

        pat[0] = 8'b1010_1010;
        pat[1] = 8'b1100_1100;
        pat[2] = 8'b1111_0000;
        pat[3] = 8'b0000_1111;

        // rst_n  en   sel    out     out_q  valid chg
        tbl[0]  = '{1'b0, 1'b0, 2'd0, 8'hAA, 8'h00, 1'b0, 1'b0}; // sweep in reset
        tbl[1]  = '{1'b0, 1'b0, 2'd1, 8'hCC, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'd2, 8'hF0, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'd3, 8'h0F, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd2, 8'hF0, 8'h00, 1'b0, 1'b0}; // reset beats en
        tbl[5]  = '{1'b0, 1'b1, 2'd2, 8'hF0, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 2'd1, 8'hCC, 8'hCC, 1'b1, 1'b0}; // first capture
        tbl[7]  = '{1'b1, 1'b1, 2'd3, 8'h0F, 8'h0F, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 2'd0, 8'hAA, 8'h0F, 1'b0, 1'b0}; // hold
        tbl[9]  = '{1'b1, 1'b1, 2'd0, 8'hAA, 8'hAA, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 2'd0, 8'hAA, 8'h00, 1'b0, 1'b0}; // mid-stream reset
        tbl[11] = '{1'b1, 1'b1, 2'd2, 8'hF0, 8'hF0, 1'b1, 1'b0}; // no stale pulse
        tbl[12] = '{1'b1, 1'b1, 2'd2, 8'hF0, 8'hF0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 2'd3, 8'h0F, 8'h0F, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 2'd3, 8'h0F, 8'h0F, 1'b1, 1'b0}; // pulse is one cycle

        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].en, tbl[i].sel, pat,
                  tbl[i].exp_out, tbl[i].exp_q, tbl[i].exp_valid, tbl[i].exp_chg);
        end

`ifdef MUX_4TO1_PARITY_EN
        apply("par_rst", 1'b0, 1'b0, 2'd0, pat, 8'hAA, 8'h00, 1'b0, 1'b0);
        apply("par_even", 1'b1, 1'b1, 2'd0, pat, 8'hAA, 8'hAA, 1'b1, 1'b0);
        pat[0] = 8'b1010_1011;
        apply("par_odd", 1'b1, 1'b1, 2'd0, pat, 8'hAB, 8'hAB, 1'b1, 1'b0);
        check("par_odd.literal", 32'(out_par), 32'd1);
`endif

        // Randomized phase: start from reset so the model state is known.
        m_last = -1;
        m_q    = '0;
        for (int i = 0; i < 300; i++) begin
            logic [3:0][N-1:0] din;
            logic              r, e, v, c;
            int                s;
            for (int k = 0; k < 4; k++) din[k] = N'($urandom);
            r = (i == 0) ? 1'b0 : ($urandom_range(15) != 0);
            e = $urandom_range(3) != 0;
            s = $urandom_range(3);
            if (!r) begin
                m_q = '0; v = 1'b0; c = 1'b0; m_last = -1;
            end else if (e) begin
                m_q = din[s]; v = 1'b1;
                c = (m_last >= 0) && (m_last != s);
                m_last = s;
            end else begin
                v = 1'b0; c = 1'b0;
            end
            apply($sformatf("rnd%0d", i), r, e, 2'(s), din, din[s], m_q, v, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_4to1
